// File: rtl/errbit_eval_sched.sv
// Frame-level scheduler for the error-bit counting pipeline: streams frame-buffer
// chunks into the error counter, reports per-frame results and keeps BER/FER stats.
module errbit_eval_sched #(
   parameter int N                = 850,
   parameter int ROW_CHUNK_NUM    = 9,
   parameter int ERR_BIT_BITWIDTH = 13,
   parameter int ADDR_W           = 4,
   parameter int STAT_W           = 32,
   parameter int TIMEOUT_CYC      = 64
) (
   input  logic                        eval_clk,
   input  logic                        rstn,
   input  logic                        frame_valid,
   output logic                        frame_ready,
   output logic                        chunk_rd_en,
   output logic [ADDR_W-1:0]           chunk_rd_addr,
   input  logic [N-1:0]                chunk_rd_data,
   output logic                        cnt_en,
   output logic [N-1:0]                cnt_hard_frame,
   input  logic                        cnt_count_done,
   input  logic [ERR_BIT_BITWIDTH-1:0] cnt_err_count,
   output logic                        res_valid,
   output logic [ERR_BIT_BITWIDTH-1:0] res_err_bits,
   output logic                        res_err_frame,
   input  logic [STAT_W-1:0]           cfg_max_frames,
   input  logic [STAT_W-1:0]           cfg_max_err_frames,
   input  logic                        stat_clr,
   output logic [STAT_W-1:0]           frame_cnt,
   output logic [STAT_W-1:0]           err_frame_cnt,
   output logic [STAT_W-1:0]           err_bit_total,
   output logic                        sim_done,
   output logic                        timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_CHUNK_NUM - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
   localparam int PAD_W = STAT_W + 1 - ERR_BIT_BITWIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT_DONE,
      S_REPORT,
      S_HALT
   } state_t;

   state_t                      state_q;
   logic                        frame_ready_q;
   logic                        rd_en_q;
   logic [ADDR_W-1:0]           addr_q;
   logic                        rd_pend_q;
   logic                        cnt_en_q;
   logic [N-1:0]                hard_q;
   logic                        done_prev_q;
   logic [WD_W-1:0]             wd_q;
   logic                        res_valid_q;
   logic [ERR_BIT_BITWIDTH-1:0] res_bits_q;
   logic                        res_ef_q;
   logic [STAT_W-1:0]           frame_cnt_q;
   logic [STAT_W-1:0]           err_frame_cnt_q;
   logic [STAT_W-1:0]           err_bit_total_q;
   logic                        sim_done_q;
   logic                        timeout_q;

   logic                        done_rise;
   logic [STAT_W-1:0]           frame_cnt_d;
   logic [STAT_W-1:0]           err_frame_cnt_d;
   logic [STAT_W-1:0]           err_bit_total_d;
   logic [STAT_W:0]             bit_sum;
   logic                        budget_hit;

   // Statistics after this frame, saturating at all-ones
   always_comb begin
      done_rise       = cnt_count_done & ~done_prev_q;
      frame_cnt_d     = frame_cnt_q;
      err_frame_cnt_d = err_frame_cnt_q;
      err_bit_total_d = err_bit_total_q;
      bit_sum         = {1'b0, err_bit_total_q}
                      + {{PAD_W{1'b0}}, res_bits_q};
      if (frame_cnt_q != '1) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end
      if (res_ef_q && (err_frame_cnt_q != '1)) begin
         err_frame_cnt_d = err_frame_cnt_q + 1'b1;
      end
      if (bit_sum[STAT_W]) begin
         err_bit_total_d = '1;
      end else begin
         err_bit_total_d = bit_sum[STAT_W-1:0];
      end
      budget_hit =
         ((cfg_max_frames != '0) &&
          (frame_cnt_d == cfg_max_frames)) ||
         ((cfg_max_err_frames != '0) &&
          (err_frame_cnt_d == cfg_max_err_frames));
   end

   always_ff @(posedge eval_clk) begin
      if (!rstn) begin
         state_q         <= S_IDLE;
         frame_ready_q   <= 1'b0;
         rd_en_q         <= 1'b0;
         addr_q          <= '0;
         rd_pend_q       <= 1'b0;
         cnt_en_q        <= 1'b0;
         hard_q          <= '0;
         done_prev_q     <= 1'b0;
         wd_q            <= '0;
         res_valid_q     <= 1'b0;
         res_bits_q      <= '0;
         res_ef_q        <= 1'b0;
         frame_cnt_q     <= '0;
         err_frame_cnt_q <= '0;
         err_bit_total_q <= '0;
         sim_done_q      <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         done_prev_q <= cnt_count_done;
         res_valid_q <= 1'b0;
         rd_pend_q   <= rd_en_q;

         if (rd_pend_q) begin
            hard_q <= chunk_rd_data;
         end

         // Watchdog starts with the first chunk on the counter port
         if (rd_pend_q && !cnt_en_q) begin
            cnt_en_q <= 1'b1;
            wd_q     <= '0;
         end else if (cnt_en_q) begin
            wd_q <= wd_q + 1'b1;
         end

         unique case (state_q)
            S_IDLE: begin
               frame_ready_q <= ~sim_done_q;
               if (frame_valid && frame_ready_q) begin
                  state_q       <= S_STREAM;
                  frame_ready_q <= 1'b0;
                  rd_en_q       <= 1'b1;
                  addr_q        <= '0;
               end
            end

            S_STREAM: begin
               if (addr_q == LAST_ADDR) begin
                  rd_en_q <= 1'b0;
                  state_q <= S_WAIT_DONE;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end

            S_WAIT_DONE: begin
               if (done_rise) begin
                  res_valid_q <= 1'b1;
                  res_bits_q  <= cnt_err_count;
                  res_ef_q    <= |cnt_err_count;
                  cnt_en_q    <= 1'b0;
                  state_q     <= S_REPORT;
               end else if (cnt_en_q && (wd_q == WD_LAST)) begin
                  timeout_q <= 1'b1;
                  cnt_en_q  <= 1'b0;
                  state_q   <= S_HALT;
               end
            end

            S_REPORT: begin
               if (!stat_clr) begin
                  frame_cnt_q     <= frame_cnt_d;
                  err_frame_cnt_q <= err_frame_cnt_d;
                  err_bit_total_q <= err_bit_total_d;
               end
               if (!stat_clr && budget_hit) begin
                  sim_done_q <= 1'b1;
                  state_q    <= S_HALT;
               end else begin
                  frame_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end

            S_HALT: begin
               frame_ready_q <= 1'b0;
               cnt_en_q      <= 1'b0;
               if (stat_clr) begin
                  sim_done_q    <= 1'b0;
                  timeout_q     <= 1'b0;
                  frame_ready_q <= 1'b1;
                  state_q       <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (stat_clr) begin
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            err_bit_total_q <= '0;
         end
      end
   end

   assign frame_ready    = frame_ready_q;
   assign chunk_rd_en    = rd_en_q;
   assign chunk_rd_addr  = addr_q;
   assign cnt_en         = cnt_en_q;
   assign cnt_hard_frame = hard_q;
   assign res_valid      = res_valid_q;
   assign res_err_bits   = res_bits_q;
   assign res_err_frame  = res_ef_q;
   assign frame_cnt      = frame_cnt_q;
   assign err_frame_cnt  = err_frame_cnt_q;
   assign err_bit_total  = err_bit_total_q;
   assign sim_done       = sim_done_q;
   assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_errbit_eval_sched.sv
// Directed bench for errbit_eval_sched: frame buffer and error-counter
// models around the scheduler, table-driven frames plus corner sequences.
module tb_errbit_eval_sched;

   localparam int N   = 850;
   localparam int RCN = 9;
   localparam int EBW = 13;
   localparam int AW  = 4;
   localparam int SW  = 32;
   localparam int TO  = 64;
   localparam int DL  = 12;

   logic           eval_clk = 1'b0;
   logic           rstn;
   logic           frame_valid;
   logic           frame_ready;
   logic           chunk_rd_en;
   logic [AW-1:0]  chunk_rd_addr;
   logic [N-1:0]   chunk_rd_data = '0;
   logic           cnt_en;
   logic [N-1:0]   cnt_hard_frame;
   logic           cnt_count_done = 1'b0;
   logic [EBW-1:0] model_err;
   logic           res_valid;
   logic [EBW-1:0] res_err_bits;
   logic           res_err_frame;
   logic [SW-1:0]  cfg_max_frames;
   logic [SW-1:0]  cfg_max_err_frames;
   logic           stat_clr;
   logic [SW-1:0]  frame_cnt;
   logic [SW-1:0]  err_frame_cnt;
   logic [SW-1:0]  err_bit_total;
   logic           sim_done;
   logic           timeout_err;

   errbit_eval_sched #(
      .N(N), .ROW_CHUNK_NUM(RCN), .ERR_BIT_BITWIDTH(EBW),
      .ADDR_W(AW), .STAT_W(SW), .TIMEOUT_CYC(TO)
   ) dut (
      .eval_clk(eval_clk), .rstn(rstn),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .chunk_rd_en(chunk_rd_en), .chunk_rd_addr(chunk_rd_addr),
      .chunk_rd_data(chunk_rd_data),
      .cnt_en(cnt_en), .cnt_hard_frame(cnt_hard_frame),
      .cnt_count_done(cnt_count_done), .cnt_err_count(model_err),
      .res_valid(res_valid), .res_err_bits(res_err_bits),
      .res_err_frame(res_err_frame),
      .cfg_max_frames(cfg_max_frames),
      .cfg_max_err_frames(cfg_max_err_frames),
      .stat_clr(stat_clr),
      .frame_cnt(frame_cnt), .err_frame_cnt(err_frame_cnt),
      .err_bit_total(err_bit_total),
      .sim_done(sim_done), .timeout_err(timeout_err)
   );

   always #5 eval_clk = ~eval_clk;

   logic [N-1:0] mem [RCN];

   always @(posedge eval_clk) begin
      if (chunk_rd_en) chunk_rd_data <= mem[chunk_rd_addr];
   end

   // Counter model: 2-cycle done pulse DL cycles after cnt_en rises
   bit         done_en    = 1'b1;
   bit         done_force = 1'b0;
   logic [7:0] m_cnt      = '0;
   logic       m_prev     = 1'b0;

   always @(posedge eval_clk) begin
      m_prev <= cnt_en;
      if (cnt_en && !m_prev) m_cnt <= 8'd1;
      else if (m_cnt != 8'd0 && m_cnt != 8'hff) m_cnt <= m_cnt + 8'd1;
      cnt_count_done <= done_force ||
         (done_en && (m_cnt == 8'(DL) || m_cnt == 8'(DL + 1)));
   end

   int cyc = 0, hs_cnt = 0, rv_cnt = 0, en_rise = 0, to_rise = 0;
   logic en_prev = 1'b0, to_prev = 1'b0;

   always @(posedge eval_clk) begin
      cyc <= cyc + 1;
      if (frame_valid && frame_ready) hs_cnt <= hs_cnt + 1;
      if (res_valid) rv_cnt <= rv_cnt + 1;
      if (cnt_en && !en_prev) en_rise <= cyc;
      if (timeout_err && !to_prev) to_rise <= cyc;
      en_prev <= cnt_en;
      to_prev <= timeout_err;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic handshake();
      int w = 0;
      @(negedge eval_clk);
      while (!frame_ready && w < 100) begin
         @(negedge eval_clk);
         w++;
      end
      frame_valid = 1'b1;
      @(negedge eval_clk);
      frame_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge eval_clk);
      stat_clr = 1'b1;
      @(negedge eval_clk);
      stat_clr = 1'b0;
   endtask

   task automatic run_frame(input logic [EBW-1:0] err, input bit detail,
                            input bit clr_rep, output bit got,
                            output logic [EBW-1:0] bits, output logic ef,
                            output int rdy_bad, output int seq_bad);
      got = 0; bits = '0; ef = 1'b0; rdy_bad = 0; seq_bad = 0;
      model_err = err;
      handshake();
      for (int n = 0; n < 300; n++) begin
         if (detail) begin
            if (n <= 8 && !(chunk_rd_en && chunk_rd_addr == AW'(n)))
               seq_bad++;
            if (n >= 9 && chunk_rd_en) seq_bad++;
            if (n < 2 && cnt_en) seq_bad++;
            if (n >= 2 && n <= 15 && !cnt_en) seq_bad++;
            if (n >= 2 && n <= 10 && cnt_hard_frame !== mem[n-2]) seq_bad++;
            if (n >= 11 && n <= 15 && cnt_hard_frame !== mem[RCN-1])
               seq_bad++;
         end
         if (res_valid) begin
            got  = 1;
            bits = res_err_bits;
            ef   = res_err_frame;
            if (detail && (n != DL + 4 || cnt_en)) seq_bad++;
            break;
         end
         if (frame_ready) rdy_bad++;
         @(negedge eval_clk);
      end
      if (clr_rep) stat_clr = 1'b1;
      @(negedge eval_clk);
      stat_clr = 1'b0;
      if (res_valid) seq_bad++;
   endtask

   typedef struct {
      bit             clr;
      logic [EBW-1:0] err;
      logic [EBW-1:0] xbits;
      logic           xef;
      logic [SW-1:0]  xfc;
      logic [SW-1:0]  xefc;
      logic [SW-1:0]  xebt;
   } vec_t;

   vec_t tbl [5];

   initial begin
      bit got;
      logic [EBW-1:0] bits;
      logic ef;
      int rb, sb, hs0, rv0, w, rdy_hi;

      tbl[0] = '{0, 13'd0,    13'd0,    1'b0, 1, 0, 0};
      tbl[1] = '{1, 13'd5,    13'd5,    1'b1, 1, 1, 5};
      tbl[2] = '{0, 13'd0,    13'd0,    1'b0, 2, 1, 5};
      tbl[3] = '{0, 13'd17,   13'd17,   1'b1, 3, 2, 22};
      tbl[4] = '{0, 13'd8191, 13'd8191, 1'b1, 4, 3, 8213};

      for (int k = 0; k < RCN; k++) begin
         mem[k] = '0;
         mem[k][k*90 +: 8] = 8'hA5 ^ 8'(k);
      end

      rstn = 1'b0; frame_valid = 1'b0; stat_clr = 1'b0;
      cfg_max_frames = '0; cfg_max_err_frames = '0; model_err = '0;
      repeat (3) @(negedge eval_clk);
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_cnt_en", cnt_en, 0);
      chk("rst_rd_en", chunk_rd_en, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_stats", {frame_cnt, err_frame_cnt} | err_bit_total, 0);
      chk("rst_flags", {sim_done, timeout_err}, 0);
      rstn = 1'b1;
      @(negedge eval_clk);
      chk("rst_release_ready", frame_ready, 1);

      for (int i = 0; i < 5; i++) begin
         if (tbl[i].clr) pulse_clr();
         run_frame(tbl[i].err, i == 0, 1'b0, got, bits, ef, rb, sb);
         chk($sformatf("v%0d_res_seen", i), got, 1);
         chk($sformatf("v%0d_res_bits", i), bits, tbl[i].xbits);
         chk($sformatf("v%0d_res_ef", i), ef, tbl[i].xef);
         chk($sformatf("v%0d_frame_cnt", i), frame_cnt, tbl[i].xfc);
         chk($sformatf("v%0d_err_frames", i), err_frame_cnt, tbl[i].xefc);
         chk($sformatf("v%0d_err_bits", i), err_bit_total, tbl[i].xebt);
         chk($sformatf("v%0d_ready_low", i), rb, 0);
         chk($sformatf("v%0d_sequence", i), sb, 0);
      end

      // Clear coinciding with REPORT: result pulses, frame not counted
      run_frame(13'd4, 1'b0, 1'b1, got, bits, ef, rb, sb);
      chk("clr_rep_res_seen", got, 1);
      chk("clr_rep_bits", bits, 4);
      chk("clr_rep_frame_cnt", frame_cnt, 0);
      chk("clr_rep_err_bits", err_bit_total, 0);
      chk("clr_rep_not_halted", sim_done, 0);

      // Back-to-back frames with frame_valid held high
      hs0 = hs_cnt; rv0 = rv_cnt;
      model_err = 13'd2;
      @(negedge eval_clk);
      frame_valid = 1'b1;
      w = 0;
      while (w < 400 && (rv_cnt - rv0) < 3) begin
         @(negedge eval_clk);
         if (hs_cnt - hs0 >= 3) frame_valid = 1'b0;
         w++;
      end
      frame_valid = 1'b0;
      repeat (3) @(negedge eval_clk);
      chk("b2b_handshakes", hs_cnt - hs0, 3);
      chk("b2b_results", rv_cnt - rv0, 3);
      chk("b2b_frame_cnt", frame_cnt, 3);
      chk("b2b_err_bits", err_bit_total, 6);

      // Reset during STREAM at chunk address 4
      rv0 = rv_cnt;
      handshake();
      w = 0;
      while (w < 20 && chunk_rd_addr != AW'(4)) begin
         @(negedge eval_clk);
         w++;
      end
      chk("mid_rst_addr4_cnt_en", cnt_en, 1);
      rstn = 1'b0;
      @(negedge eval_clk);
      chk("mid_rst_cnt_en", cnt_en, 0);
      chk("mid_rst_frame_cnt", frame_cnt, 0);
      chk("mid_rst_err_bits", err_bit_total, 0);
      rstn = 1'b1;
      @(negedge eval_clk);
      chk("mid_rst_ready", frame_ready, 1);
      repeat (30) @(negedge eval_clk);
      chk("mid_rst_no_result", rv_cnt - rv0, 0);

      // Error-frame budget of 2
      cfg_max_err_frames = 32'd2;
      run_frame(13'd3, 1'b0, 1'b0, got, bits, ef, rb, sb);
      chk("bud1_sim_done", sim_done, 0);
      run_frame(13'd1, 1'b0, 1'b0, got, bits, ef, rb, sb);
      chk("bud2_sim_done", sim_done, 1);
      chk("bud2_err_frames", err_frame_cnt, 2);
      chk("bud2_err_bits", err_bit_total, 4);
      hs0 = hs_cnt; rdy_hi = 0;
      frame_valid = 1'b1;
      repeat (6) begin
         @(negedge eval_clk);
         if (frame_ready) rdy_hi++;
      end
      chk("halt_ready_low", rdy_hi, 0);
      chk("halt_no_handshake", hs_cnt - hs0, 0);
      frame_valid = 1'b0;
      stat_clr = 1'b1;
      @(negedge eval_clk);
      stat_clr = 1'b0;
      chk("halt_clr_stats", {frame_cnt, err_frame_cnt} | err_bit_total, 0);
      chk("halt_clr_sim_done", sim_done, 0);
      chk("halt_clr_ready", frame_ready, 1);
      cfg_max_err_frames = '0;

      // Watchdog: counter never signals done
      done_en = 1'b0; rv0 = rv_cnt;
      handshake();
      w = 0;
      while (w < 200 && !timeout_err) begin
         @(negedge eval_clk);
         w++;
      end
      @(negedge eval_clk);
      chk("to_flag", timeout_err, 1);
      chk("to_latency", to_rise - en_rise, TO);
      chk("to_cnt_en", cnt_en, 0);
      repeat (3) @(negedge eval_clk);
      chk("to_halt_ready", frame_ready, 0);
      chk("to_no_result", rv_cnt - rv0, 0);
      pulse_clr();
      chk("to_clr_flag", timeout_err, 0);
      chk("to_clr_ready", frame_ready, 1);

      // Done level already high before WAIT_DONE is not an edge
      done_force = 1'b1; rv0 = rv_cnt;
      repeat (2) @(negedge eval_clk);
      handshake();
      w = 0;
      while (w < 200 && !timeout_err) begin
         @(negedge eval_clk);
         w++;
      end
      chk("lvl_timeout", timeout_err, 1);
      chk("lvl_no_result", rv_cnt - rv0, 0);
      done_force = 1'b0;
      pulse_clr();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
